// File: rtl/ovl_fire_pkg.sv
// Shared event types for the OVL fire collector.
// Build macro OVL_FIRE_COVER_EN enables cover (fire bit2) events.
package ovl_fire_pkg;

   typedef enum logic [1:0] {
      EVT_ASSERT = 2'd0,
      EVT_XCHECK = 2'd1,
      EVT_COVER  = 2'd2
   } evt_type_e;

`ifdef OVL_FIRE_COVER_EN
   localparam int unsigned NUM_TYPES = 3;
`else
   localparam int unsigned NUM_TYPES = 2;
`endif

   // Event fields are sized for the largest supported configuration.
   localparam int unsigned EVT_CHK_W = 8;
   localparam int unsigned EVT_TS_W  = 32;

   typedef struct packed {
      logic [EVT_CHK_W-1:0] chk;
      evt_type_e            evt_type;
      logic [EVT_TS_W-1:0]  ts;
   } ovl_evt_t;

endpackage

// File: rtl/ovl_fire_fifo.sv
// Synchronous show-ahead FIFO of fire events; head is visible on rdata_o while not empty.
module ovl_fire_fifo
   import ovl_fire_pkg::*;
#(
   parameter int unsigned Depth = 8
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  logic     clr_i,
   input  logic     wr_en_i,
   input  ovl_evt_t wdata_i,
   output logic     full_o,
   input  logic     rd_en_i,
   output ovl_evt_t rdata_o,
   output logic     empty_o
);

   localparam int unsigned AddrW = $clog2(Depth);

   // Extra MSB on each pointer distinguishes full from empty.
   logic [AddrW:0] wr_ptr_q, wr_ptr_d;
   logic [AddrW:0] rd_ptr_q, rd_ptr_d;
   ovl_evt_t       mem_q [Depth];
   logic           do_wr, do_rd;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                    (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
   assign do_wr   = wr_en_i & ~full_o;
   assign do_rd   = rd_en_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

   always_comb begin
      wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_wr && !clr_i) begin
         mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/ovl_fire_collector.sv
// Collects OVL checker fires: per-checker fail counters, first-fail latch and an event stream.
// Build macro OVL_FIRE_COVER_EN adds cover (fire bit2) events.
module ovl_fire_collector
   import ovl_fire_pkg::*;
#(
   parameter int unsigned NUM_CHK    = 4,
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned TS_W       = 16,
   parameter int unsigned FIFO_DEPTH = 8,
   localparam int unsigned ChkW      = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     enable_i,
   input  logic                     clr_i,
   input  logic [3*NUM_CHK-1:0]     fire_in_i,
   output logic                     evt_valid_o,
   input  logic                     evt_ready_i,
   output logic [ChkW-1:0]          evt_chk_o,
   output logic [1:0]               evt_type_o,
   output logic [TS_W-1:0]          evt_ts_o,
   output logic [NUM_CHK*CNT_W-1:0] fail_cnt_o,
   output logic                     any_fail_o,
   output logic [ChkW-1:0]          first_fail_chk_o,
   output logic [TS_W-1:0]          first_fail_ts_o,
   output logic                     overflow_o
);

   localparam int unsigned PendW = NUM_CHK * NUM_TYPES;

   logic [TS_W-1:0]               ts_q, ts_d;
   logic [NUM_CHK-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic                          any_fail_q, any_fail_d;
   logic [ChkW-1:0]               ff_chk_q, ff_chk_d;
   logic [TS_W-1:0]               ff_ts_q, ff_ts_d;
   logic [PendW-1:0]              pend_q, pend_d;
   logic                          overflow_q, overflow_d;
   logic [PendW-1:0]              fire_s, pop_mask, pop_clr;
   logic                          pop_found;
   logic [ChkW-1:0]               pop_chk;
   evt_type_e                     pop_type;
   logic                          fifo_wr, fifo_rd, fifo_full, fifo_empty;
   ovl_evt_t                      fifo_wdata, fifo_rdata;
   logic                          unused_bits;

   // Flattened as chk*NUM_TYPES + type, so ascending index is pop priority.
   always_comb begin
      fire_s = '0;
      for (int unsigned c = 0; c < NUM_CHK; c++) begin
         for (int unsigned t = 0; t < NUM_TYPES; t++) begin
            fire_s[c*NUM_TYPES + t] = enable_i & fire_in_i[3*c + t];
         end
      end
   end

   always_comb begin
      pop_found = 1'b0;
      pop_chk   = '0;
      pop_type  = EVT_ASSERT;
      pop_mask  = '0;
      for (int unsigned c = 0; c < NUM_CHK; c++) begin
         for (int unsigned t = 0; t < NUM_TYPES; t++) begin
            if (!pop_found && pend_q[c*NUM_TYPES + t]) begin
               pop_found                    = 1'b1;
               pop_chk                      = ChkW'(c);
               pop_type                     = evt_type_e'(2'(t));
               pop_mask[c*NUM_TYPES + t]    = 1'b1;
            end
         end
      end
   end

   // Fullness is judged at cycle start, so a same-cycle read never admits a write.
   assign fifo_wr    = pop_found & ~fifo_full;
   assign pop_clr    = fifo_wr ? pop_mask : '0;
   assign fifo_rd    = evt_valid_o & evt_ready_i;
   assign fifo_wdata = '{chk: EVT_CHK_W'(pop_chk), evt_type: pop_type, ts: EVT_TS_W'(ts_q)};

   always_comb begin
      ts_d       = enable_i ? ts_q + 1'b1 : ts_q;
      cnt_d      = cnt_q;
      any_fail_d = any_fail_q;
      ff_chk_d   = ff_chk_q;
      ff_ts_d    = ff_ts_q;
      pend_d     = (pend_q & ~pop_clr) | fire_s;
      overflow_d = overflow_q | (|(fire_s & pend_q & ~pop_clr));
      // Walk from the highest checker down so the lowest simultaneous fail wins.
      for (int unsigned i = 0; i < NUM_CHK; i++) begin
         if (fire_s[(NUM_CHK-1-i)*NUM_TYPES]) begin
            if (cnt_q[NUM_CHK-1-i] != '1) begin
               cnt_d[NUM_CHK-1-i] = cnt_q[NUM_CHK-1-i] + 1'b1;
            end
            if (!any_fail_q) begin
               any_fail_d = 1'b1;
               ff_chk_d   = ChkW'(NUM_CHK-1-i);
               ff_ts_d    = ts_q;
            end
         end
      end
      if (clr_i) begin
         ts_d       = '0;
         cnt_d      = '0;
         any_fail_d = 1'b0;
         ff_chk_d   = '0;
         ff_ts_d    = '0;
         pend_d     = '0;
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ts_q       <= '0;
         cnt_q      <= '0;
         any_fail_q <= 1'b0;
         ff_chk_q   <= '0;
         ff_ts_q    <= '0;
         pend_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         ts_q       <= ts_d;
         cnt_q      <= cnt_d;
         any_fail_q <= any_fail_d;
         ff_chk_q   <= ff_chk_d;
         ff_ts_q    <= ff_ts_d;
         pend_q     <= pend_d;
         overflow_q <= overflow_d;
      end
   end

   ovl_fire_fifo #(
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (clr_i),
      .wr_en_i (fifo_wr),
      .wdata_i (fifo_wdata),
      .full_o  (fifo_full),
      .rd_en_i (fifo_rd),
      .rdata_o (fifo_rdata),
      .empty_o (fifo_empty)
   );

   assign evt_valid_o      = ~fifo_empty;
   assign evt_chk_o        = fifo_empty ? '0 : fifo_rdata.chk[ChkW-1:0];
   assign evt_type_o       = fifo_empty ? 2'b00 : fifo_rdata.evt_type;
   assign evt_ts_o         = fifo_empty ? '0 : fifo_rdata.ts[TS_W-1:0];
   assign fail_cnt_o       = cnt_q;
   assign any_fail_o       = any_fail_q;
   assign first_fail_chk_o = ff_chk_q;
   assign first_fail_ts_o  = ff_ts_q;
   assign overflow_o       = overflow_q;

   // Upper event-field bits and (without cover support) fire bit2 are intentionally dropped.
   assign unused_bits = ^{fifo_rdata.chk, fifo_rdata.ts, fire_in_i};

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Self-checking bench for ovl_fire_collector: directed scenarios plus randomized traffic
// against a queue-based reference model. Honours OVL_FIRE_COVER_EN like the RTL.
module tb_ovl_fire_collector;
   import ovl_fire_pkg::*;

   localparam int unsigned NChk  = 4;
   localparam int unsigned CntW  = 4;
   localparam int unsigned TsW   = 16;
   localparam int unsigned Depth = 8;
`ifdef OVL_FIRE_COVER_EN
   localparam int NT = 3;
`else
   localparam int NT = 2;
`endif

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b1;
   logic                   en = 1'b0, clr = 1'b0, rdy = 1'b0;
   logic [3*NChk-1:0]      fire = '0;
   logic                   evt_valid, any_fail, ovf;
   logic [1:0]             evt_chk, evt_type, ff_chk;
   logic [TsW-1:0]         evt_ts, ff_ts;
   logic [NChk*CntW-1:0]   fail_cnt;
   int                     total = 0, bad = 0;

   always #5 clk = ~clk;

   ovl_fire_collector #(
      .NUM_CHK    (NChk),
      .CNT_W      (CntW),
      .TS_W       (TsW),
      .FIFO_DEPTH (Depth)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .enable_i         (en),
      .clr_i            (clr),
      .fire_in_i        (fire),
      .evt_valid_o      (evt_valid),
      .evt_ready_i      (rdy),
      .evt_chk_o        (evt_chk),
      .evt_type_o       (evt_type),
      .evt_ts_o         (evt_ts),
      .fail_cnt_o       (fail_cnt),
      .any_fail_o       (any_fail),
      .first_fail_chk_o (ff_chk),
      .first_fail_ts_o  (ff_ts),
      .overflow_o       (ovf)
   );

   // Reference model: pending set, event queue, plain integer counters.
   typedef struct {int chk; int typ; int ts;} mevt_t;
   mevt_t mq[$];
   bit    m_pend[NChk][3];
   int    m_cnt[NChk];
   bit    m_any, m_ovf;
   int    m_ffc, m_fft, m_ts;

   task automatic model_clear();
      mq.delete();
      for (int c = 0; c < NChk; c++) begin
         m_cnt[c] = 0;
         for (int t = 0; t < 3; t++) m_pend[c][t] = 1'b0;
      end
      m_any = 0; m_ovf = 0; m_ffc = 0; m_fft = 0; m_ts = 0;
   endtask

   task automatic model_step();
      bit    full, rd, found;
      int    first;
      mevt_t e;
      if (clr) begin
         model_clear();
         return;
      end
      full  = (mq.size() == Depth);
      rd    = (mq.size() > 0) && rdy;
      found = 0;
      if (!full) begin
         for (int c = 0; c < NChk; c++) begin
            for (int t = 0; t < NT; t++) begin
               if (!found && m_pend[c][t]) begin
                  found = 1; m_pend[c][t] = 0;
                  e.chk = c; e.typ = t; e.ts = m_ts;
                  mq.push_back(e);
               end
            end
         end
      end
      if (rd) void'(mq.pop_front());
      if (en) begin
         for (int c = 0; c < NChk; c++) begin
            for (int t = 0; t < NT; t++) begin
               if (fire[3*c+t]) begin
                  if (m_pend[c][t]) m_ovf = 1;
                  m_pend[c][t] = 1;
               end
            end
         end
         first = -1;
         for (int c = 0; c < NChk; c++) begin
            if (fire[3*c]) begin
               if (m_cnt[c] < (1 << CntW) - 1) m_cnt[c]++;
               if (first < 0) first = c;
            end
         end
         if (first >= 0 && !m_any) begin
            m_any = 1; m_ffc = first; m_fft = m_ts;
         end
         m_ts = (m_ts + 1) % (1 << TsW);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_clr();
      clr = 1'b1; tick(); clr = 1'b0;
   endtask

   task automatic test_reset();
      total++;
      if (evt_valid !== 1'b0 || evt_chk !== 2'd0 || evt_type !== 2'd0 || evt_ts !== '0) begin
         bad++; $display("FAIL reset_evt: valid=%b chk=%0d type=%0d ts=%0d, want all 0",
                         evt_valid, evt_chk, evt_type, evt_ts);
      end
      total++;
      if (fail_cnt !== '0 || any_fail !== 1'b0 || ovf !== 1'b0 || ff_chk !== '0 || ff_ts !== '0) begin
         bad++; $display("FAIL reset_state: cnt=%h any=%b ovf=%b ffc=%0d fft=%0d, want all 0",
                         fail_cnt, any_fail, ovf, ff_chk, ff_ts);
      end
   endtask

   task automatic test_single();
      do_clr();
      en = 1'b1; rdy = 1'b1;
      repeat (5) tick();
      fire = 12'h001; tick(); fire = '0;
      total++;
      if (any_fail !== 1'b1 || ff_chk !== 2'd0 || ff_ts !== 16'd5 || fail_cnt[3:0] !== 4'd1) begin
         bad++; $display("FAIL single_first: any=%b ffc=%0d fft=%0d cnt0=%0d, want 1 0 5 1",
                         any_fail, ff_chk, ff_ts, fail_cnt[3:0]);
      end
      total++;
      if (evt_valid !== 1'b0) begin
         bad++; $display("FAIL single_latency_early: valid=%b, want 0", evt_valid);
      end
      tick();
      total++;
      if (evt_valid !== 1'b1 || evt_chk !== 2'd0 || evt_type !== 2'd0 || evt_ts !== 16'd6) begin
         bad++; $display("FAIL single_evt: valid=%b chk=%0d type=%0d ts=%0d, want 1 0 0 6",
                         evt_valid, evt_chk, evt_type, evt_ts);
      end
      tick();
      total++;
      if (evt_valid !== 1'b0) begin
         bad++; $display("FAIL single_drain: valid=%b, want 0", evt_valid);
      end
   endtask

   task automatic test_simultaneous();
      do_clr();
      en = 1'b1; rdy = 1'b1;
      fire = (12'h1 << 6) | (12'h1 << 4); tick(); fire = '0;
      total++;
      if (ff_chk !== 2'd2 || any_fail !== 1'b1) begin
         bad++; $display("FAIL simul_first: ffc=%0d any=%b, want 2 1", ff_chk, any_fail);
      end
      tick();
      total++;
      if (evt_valid !== 1'b1 || evt_chk !== 2'd1 || evt_type !== 2'd1) begin
         bad++; $display("FAIL simul_evt0: valid=%b chk=%0d type=%0d, want 1 1 1",
                         evt_valid, evt_chk, evt_type);
      end
      tick();
      total++;
      if (evt_valid !== 1'b1 || evt_chk !== 2'd2 || evt_type !== 2'd0) begin
         bad++; $display("FAIL simul_evt1: valid=%b chk=%0d type=%0d, want 1 2 0",
                         evt_valid, evt_chk, evt_type);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int sc[9], st[9], idx, budget;
      logic [1:0] h_chk, h_type;
      logic [TsW-1:0] h_ts;
      logic [3*NChk-1:0] f8;
      idx = 0;
      for (int c = 0; c < NChk; c++)
         for (int t = 0; t < NT; t++)
            if (idx < 8) begin sc[idx] = c; st[idx] = t; idx++; end
      sc[8] = (NT == 3) ? 2 : 0;
      st[8] = (NT == 3) ? 2 : 0;
      f8 = '0;
      for (int i = 0; i < 8; i++) f8[3*sc[i] + st[i]] = 1'b1;
      do_clr();
      en = 1'b1; rdy = 1'b0;
      fire = f8; tick(); fire = '0;
      repeat (8) tick();
      h_chk = evt_chk; h_type = evt_type; h_ts = evt_ts;
      fire = '0; fire[3*sc[8] + st[8]] = 1'b1; tick(); fire = '0;
      total++;
      if (ovf !== 1'b0 || evt_valid !== 1'b1) begin
         bad++; $display("FAIL bp_no_ovf: ovf=%b valid=%b, want 0 1", ovf, evt_valid);
      end
      total++;
      if (evt_chk !== h_chk || evt_type !== h_type || evt_ts !== h_ts ||
          evt_chk !== 2'(sc[0]) || evt_type !== 2'(st[0])) begin
         bad++; $display("FAIL bp_stable: chk=%0d type=%0d ts=%0d, want %0d %0d %0d",
                         evt_chk, evt_type, evt_ts, sc[0], st[0], h_ts);
      end
      fire[3*sc[8] + st[8]] = 1'b1; tick(); fire = '0;
      total++;
      if (ovf !== 1'b1) begin
         bad++; $display("FAIL bp_ovf: ovf=%b, want 1", ovf);
      end
      rdy = 1'b1; idx = 0; budget = 40;
      while (idx < 9 && budget > 0) begin
         if (evt_valid === 1'b1) begin
            total++;
            if (evt_chk !== 2'(sc[idx]) || evt_type !== 2'(st[idx]) ||
                mq.size() == 0 || evt_ts !== TsW'(mq[0].ts)) begin
               bad++; $display("FAIL bp_drain%0d: chk=%0d type=%0d ts=%0d, want %0d %0d %0d",
                               idx, evt_chk, evt_type, evt_ts, sc[idx], st[idx],
                               (mq.size() > 0) ? mq[0].ts : -1);
            end
            idx++;
         end
         tick(); budget--;
      end
      total++;
      if (idx != 9 || evt_valid !== 1'b0) begin
         bad++; $display("FAIL bp_count: drained=%0d valid=%b, want 9 0", idx, evt_valid);
      end
   endtask

   task automatic test_saturation();
      do_clr();
      en = 1'b1; rdy = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         fire = 12'h1 << 9; tick();
         if (i == 14 || i == 15 || i == 20) begin
            total++;
            if (fail_cnt[15:12] !== 4'((i > 15) ? 15 : i)) begin
               bad++; $display("FAIL sat_%0d: cnt3=%0d, want %0d", i, fail_cnt[15:12],
                               (i > 15) ? 15 : i);
            end
         end
      end
      fire = '0;
      total++;
      if (ovf !== 1'b0 || fail_cnt[11:0] !== '0) begin
         bad++; $display("FAIL sat_side: ovf=%b cnt_lo=%h, want 0 000", ovf, fail_cnt[11:0]);
      end
      repeat (4) tick();
   endtask

   task automatic test_clr_reset();
      do_clr();
      en = 1'b1; rdy = 1'b0;
      fire = 12'hFFF; tick(); fire = '0;
      repeat (3) tick();
      clr = 1'b1; fire = 12'h001; tick(); clr = 1'b0; fire = '0;
      total++;
      if (evt_valid !== 1'b0 || evt_ts !== '0 || fail_cnt !== '0 || any_fail !== 1'b0 ||
          ovf !== 1'b0 || ff_chk !== '0 || ff_ts !== '0) begin
         bad++; $display("FAIL clr_all: valid=%b ts=%0d cnt=%h any=%b ovf=%b ffc=%0d fft=%0d",
                         evt_valid, evt_ts, fail_cnt, any_fail, ovf, ff_chk, ff_ts);
      end
      tick();
      total++;
      if (evt_valid !== 1'b0) begin
         bad++; $display("FAIL clr_no_evt: valid=%b, want 0", evt_valid);
      end
      rdy = 1'b1;
      fire = 12'hFFF; tick(); fire = '0;
      repeat (3) tick();
      #3 rst_n = 1'b0;
      #1;
      total++;
      if (evt_valid !== 1'b0 || fail_cnt !== '0 || any_fail !== 1'b0) begin
         bad++; $display("FAIL async_reset: valid=%b cnt=%h any=%b, want 0 0 0",
                         evt_valid, fail_cnt, any_fail);
      end
      model_clear();
      #2 rst_n = 1'b1;
      tick();
      total++;
      if (evt_valid !== 1'b0) begin
         bad++; $display("FAIL reset_discard: valid=%b, want 0", evt_valid);
      end
   endtask

   task automatic test_cover();
      do_clr();
      en = 1'b1; rdy = 1'b1;
      fire = 12'h004; tick(); fire = '0;
      tick();
`ifdef OVL_FIRE_COVER_EN
      total++;
      if (evt_valid !== 1'b1 || evt_chk !== 2'd0 || evt_type !== 2'd2) begin
         bad++; $display("FAIL cover_evt: valid=%b chk=%0d type=%0d, want 1 0 2",
                         evt_valid, evt_chk, evt_type);
      end
`else
      total++;
      if (evt_valid !== 1'b0) begin
         bad++; $display("FAIL cover_none: valid=%b, want 0", evt_valid);
      end
`endif
      total++;
      if (fail_cnt !== '0 || any_fail !== 1'b0) begin
         bad++; $display("FAIL cover_cnt: cnt=%h any=%b, want 0 0", fail_cnt, any_fail);
      end
      tick();
   endtask

   task automatic test_random();
      logic [NChk*CntW-1:0] e_cnt;
      bit e_valid;
      do_clr();
      for (int n = 0; n < 400; n++) begin
         en  = ($urandom_range(3) != 0);
         rdy = ($urandom_range(2) != 0);
         clr = ($urandom_range(149) == 0);
         for (int b = 0; b < 3*NChk; b++) fire[b] = ($urandom_range(6) == 0);
         tick();
         e_valid = (mq.size() > 0);
         for (int c = 0; c < NChk; c++) e_cnt[CntW*c +: CntW] = CntW'(m_cnt[c]);
         total++;
         if (evt_valid !== e_valid ||
             (e_valid && (evt_chk !== 2'(mq[0].chk) || evt_type !== 2'(mq[0].typ) ||
                          evt_ts !== TsW'(mq[0].ts)))) begin
            bad++; $display("FAIL rnd_evt@%0d: valid=%b chk=%0d type=%0d ts=%0d, want valid=%b",
                            n, evt_valid, evt_chk, evt_type, evt_ts, e_valid);
         end
         total++;
         if (fail_cnt !== e_cnt || ovf !== m_ovf || any_fail !== m_any ||
             (m_any && (ff_chk !== 2'(m_ffc) || ff_ts !== TsW'(m_fft)))) begin
            bad++; $display("FAIL rnd_state@%0d: cnt=%h ovf=%b any=%b ffc=%0d fft=%0d, want %h %b %b %0d %0d",
                            n, fail_cnt, ovf, any_fail, ff_chk, ff_ts, e_cnt, m_ovf, m_any,
                            m_ffc, m_fft);
         end
      end
      clr = 1'b0; fire = '0;
   endtask

   initial begin
      model_clear();
      #2 rst_n = 1'b0;
      #10 rst_n = 1'b1;
      test_reset();
      test_single();
      test_simultaneous();
      test_backpressure();
      test_saturation();
      test_clr_reset();
      test_cover();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
